// File: rtl/bypass_scoreboard.sv
// -----------------------------------------------------------------------------
// bypass_scoreboard
//
// Operand-bypass and load-use hazard unit that sits beside decode.
// Every instruction leaving decode is recorded in a PIPE_DEPTH-deep
// shift-register scoreboard (index 0 = stage 1 = youngest). Each read port
// forwards from the youngest in-flight producer of its source register.
// If that producer is a load whose data is not valid yet, a stall is raised.
//
// Optional feature: define BYPASS_PERF_EN to add the performance counters
// (perf_clr input, perf_stall_cnt / perf_fwd_cnt outputs).
//
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   hold              external back-pressure, freezes the scoreboard
//   issue_*           record of the instruction currently in decode
//   rd_use/rd_addr    per-port read enable and source address
//   rf_data, rf_ps    register-file read data and predicate bit
//   read_ps           instruction reads the predicate
//   stg_data, stg_ps  result data / predicate of post-decode stages 1..PIPE_DEPTH
//   op_data, op_ps    resolved operands and predicate
//   stall             load-use hazard, decode re-presents the instruction
//   perf_*            (BYPASS_PERF_EN only) stall and forwarding counters
//
// LOAD_LAT must satisfy 1 <= LOAD_LAT <= PIPE_DEPTH.
// -----------------------------------------------------------------------------
module bypass_scoreboard #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4,
  parameter int NUM_READ   = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 2
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           hold,
  input  logic                           issue_valid,
  input  logic                           issue_use_rw,
  input  logic [REG_ADDR_W-1:0]          issue_rw_addr,
  input  logic                           issue_is_load,
  input  logic                           issue_write_ps,
  input  logic [NUM_READ-1:0]            rd_use,
  input  logic [NUM_READ*REG_ADDR_W-1:0] rd_addr,
  input  logic [NUM_READ*DATA_W-1:0]     rf_data,
  input  logic                           read_ps,
  input  logic                           rf_ps,
  input  logic [PIPE_DEPTH*DATA_W-1:0]   stg_data,
  input  logic [PIPE_DEPTH-1:0]          stg_ps,
  output logic [NUM_READ*DATA_W-1:0]     op_data,
  output logic                           op_ps,
  output logic                           stall
`ifdef BYPASS_PERF_EN
  ,
  input  logic                           perf_clr,
  output logic [31:0]                    perf_stall_cnt,
  output logic [31:0]                    perf_fwd_cnt
`endif
);

  // Scoreboard entries, bit/element k holds stage k+1.
  logic [PIPE_DEPTH-1:0] r_valid;
  logic [PIPE_DEPTH-1:0] r_use_rw;
  logic [PIPE_DEPTH-1:0] r_is_load;
  logic [PIPE_DEPTH-1:0] r_write_ps;
  logic [REG_ADDR_W-1:0] r_rw_addr [PIPE_DEPTH];

  logic [NUM_READ-1:0]   w_port_hazard;
  logic [NUM_READ-1:0]   w_port_fwd;

  // ---------------------------------------------------------------------------
  // Per-port operand resolution
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_port
      logic [REG_ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0]     w_data;
      logic                  w_haz;
      logic                  w_fwd;

      assign w_addr = rd_addr[gi*REG_ADDR_W +: REG_ADDR_W];

      // Scan from oldest to youngest so the youngest match is the last
      // assignment and therefore wins.
      always_comb begin
        w_data = rf_data[gi*DATA_W +: DATA_W];
        w_haz  = 1'b0;
        w_fwd  = 1'b0;
        if (rd_use[gi]) begin
          for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (r_valid[k] && r_use_rw[k] && (r_rw_addr[k] == w_addr)) begin
              w_data = stg_data[k*DATA_W +: DATA_W];
              // Load data first appears at stage LOAD_LAT (stage = k+1).
              w_haz  = r_is_load[k] && ((k + 1) < LOAD_LAT);
              w_fwd  = 1'b1;
            end
          end
        end
      end

      assign op_data[gi*DATA_W +: DATA_W] = w_data;
      assign w_port_hazard[gi]            = w_haz;
      assign w_port_fwd[gi]               = w_fwd;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Predicate resolution; predicate writers are never loads, so no hazard.
  // ---------------------------------------------------------------------------
  always_comb begin
    op_ps = rf_ps;
    if (read_ps) begin
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
        if (r_valid[k] && r_write_ps[k]) begin
          op_ps = stg_ps[k];
        end
      end
    end
  end

  assign stall = issue_valid & (|w_port_hazard);

  // ---------------------------------------------------------------------------
  // Scoreboard shift register. A stalled instruction enters as a bubble.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_valid    <= '0;
      r_use_rw   <= '0;
      r_is_load  <= '0;
      r_write_ps <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        r_rw_addr[k] <= '0;
      end
    end else if (!hold) begin
      for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
        r_valid[k]    <= r_valid[k-1];
        r_use_rw[k]   <= r_use_rw[k-1];
        r_is_load[k]  <= r_is_load[k-1];
        r_write_ps[k] <= r_write_ps[k-1];
        r_rw_addr[k]  <= r_rw_addr[k-1];
      end
      r_valid[0]    <= issue_valid & ~stall;
      r_use_rw[0]   <= issue_use_rw;
      r_is_load[0]  <= issue_is_load;
      r_write_ps[0] <= issue_write_ps;
      r_rw_addr[0]  <= issue_rw_addr;
    end
  end

`ifdef BYPASS_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_fwd_cnt;
  logic [31:0] w_fwd_num;

  // Not-ready matches are also flagged in w_port_fwd, but they only occur
  // together with stall=1, when the forwarding count is not accumulated.
  always_comb begin
    w_fwd_num = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      w_fwd_num = w_fwd_num + 32'(w_port_fwd[p]);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_perf_stall_cnt <= '0;
      r_perf_fwd_cnt   <= '0;
    end else if (perf_clr) begin
      r_perf_stall_cnt <= '0;
      r_perf_fwd_cnt   <= '0;
    end else begin
      if (stall && !hold) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
      if (issue_valid && !stall) begin
        r_perf_fwd_cnt <= r_perf_fwd_cnt + w_fwd_num;
      end
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_fwd_cnt   = r_perf_fwd_cnt;
`endif

endmodule

// File: tb/tb_bypass_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_bypass_scoreboard
//
// Self-checking bench for bypass_scoreboard (default parameters):
//   - hand sequence around asynchronous reset,
//   - table of per-cycle vectors with hand-computed expectations,
//   - performance-counter sequence when BYPASS_PERF_EN is defined,
//   - randomized stimulus against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_bypass_scoreboard;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 2;
  localparam int PD = 3;
  localparam int LL = 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          hold;
  logic          issue_valid;
  logic          issue_use_rw;
  logic [AW-1:0] issue_rw_addr;
  logic          issue_is_load;
  logic          issue_write_ps;
  logic [NR-1:0]    rd_use;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rf_data;
  logic             read_ps;
  logic             rf_ps;
  logic [PD*DW-1:0] stg_data;
  logic [PD-1:0]    stg_ps;
  logic [NR*DW-1:0] op_data;
  logic             op_ps;
  logic             stall;
`ifdef BYPASS_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_fwd_cnt;
`endif

  always #5 clk = ~clk;

  bypass_scoreboard #(
    .DATA_W(DW), .REG_ADDR_W(AW), .NUM_READ(NR), .PIPE_DEPTH(PD), .LOAD_LAT(LL)
  ) dut (
    .clk(clk), .n_rst(n_rst), .hold(hold),
    .issue_valid(issue_valid), .issue_use_rw(issue_use_rw),
    .issue_rw_addr(issue_rw_addr), .issue_is_load(issue_is_load),
    .issue_write_ps(issue_write_ps),
    .rd_use(rd_use), .rd_addr(rd_addr), .rf_data(rf_data),
    .read_ps(read_ps), .rf_ps(rf_ps),
    .stg_data(stg_data), .stg_ps(stg_ps),
    .op_data(op_data), .op_ps(op_ps), .stall(stall)
`ifdef BYPASS_PERF_EN
    , .perf_clr(perf_clr), .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          hold, iv, iuse;
    logic [AW-1:0] iaddr;
    logic          iload, iwps;
    logic [1:0]    ruse;
    logic [AW-1:0] ra0, ra1;
    logic          rps;
    logic [DW-1:0] e0, e1;
    logic          eps, est;
  } vec_t;

  function automatic vec_t mk(input logic h, input logic iv, input logic iu,
                              input logic [AW-1:0] ia, input logic il, input logic iw,
                              input logic [1:0] ru, input logic [AW-1:0] a0,
                              input logic [AW-1:0] a1, input logic rp,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                              input logic ep, input logic es);
    vec_t v;
    v.hold = h; v.iv = iv; v.iuse = iu; v.iaddr = ia; v.iload = il; v.iwps = iw;
    v.ruse = ru; v.ra0 = a0; v.ra1 = a1; v.rps = rp;
    v.e0 = e0; v.e1 = e1; v.eps = ep; v.est = es;
    return v;
  endfunction

  localparam int NVEC = 23;
  vec_t vt [NVEC];

  task automatic drive_idle();
    hold = 0; issue_valid = 0; issue_use_rw = 0; issue_rw_addr = '0;
    issue_is_load = 0; issue_write_ps = 0; rd_use = '0; rd_addr = '0; read_ps = 0;
  endtask

  task automatic drive_issue(input logic iv, input logic iu, input logic [AW-1:0] ia,
                             input logic il, input logic iw);
    issue_valid = iv; issue_use_rw = iu; issue_rw_addr = ia;
    issue_is_load = il; issue_write_ps = iw;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the scoreboard is the list of the last PD accepted
  // decode slots, youngest first.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          v, u;
    logic [AW-1:0] a;
    logic          ld, wp;
  } ent_t;

  ent_t mdl_q[$];
  logic [31:0] mdl_stall_cnt;
  logic [31:0] mdl_fwd_cnt;

  task automatic model_reset();
    ent_t e;
    e.v = 0; e.u = 0; e.a = '0; e.ld = 0; e.wp = 0;
    mdl_q.delete();
    for (int i = 0; i < PD; i++) mdl_q.push_back(e);
    mdl_stall_cnt = '0;
    mdl_fwd_cnt   = '0;
  endtask

  function automatic void model_eval(output logic [DW-1:0] e0, output logic [DW-1:0] e1,
                                     output logic eps, output logic est, output int nfwd);
    logic [DW-1:0] ed [NR];
    logic haz;
    logic found;
    haz  = 1'b0;
    nfwd = 0;
    for (int p = 0; p < NR; p++) begin
      ed[p] = rf_data[p*DW +: DW];
      found = 1'b0;
      if (rd_use[p]) begin
        for (int k = 0; k < PD; k++) begin
          if (!found && mdl_q[k].v && mdl_q[k].u && mdl_q[k].a == rd_addr[p*AW +: AW]) begin
            found = 1'b1;
            ed[p] = stg_data[k*DW +: DW];
            if (mdl_q[k].ld && (k + 1) < LL) haz = 1'b1;
          end
        end
      end
      if (found) nfwd++;
    end
    eps = rf_ps;
    found = 1'b0;
    if (read_ps) begin
      for (int k = 0; k < PD; k++) begin
        if (!found && mdl_q[k].v && mdl_q[k].wp) begin
          found = 1'b1;
          eps = stg_ps[k];
        end
      end
    end
    e0  = ed[0];
    e1  = ed[1];
    est = issue_valid & haz;
  endfunction

  task automatic model_clock(input logic exp_stall);
    ent_t e;
    if (!hold) begin
      e.v = issue_valid & ~exp_stall; e.u = issue_use_rw; e.a = issue_rw_addr;
      e.ld = issue_is_load; e.wp = issue_write_ps;
      mdl_q.push_front(e);
      void'(mdl_q.pop_back());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] e0, e1;
    logic eps, est;
    int nfwd;

    // Table rows: hold iv iuse iaddr iload iwps ruse ra0 ra1 rps | e0 e1 eps est
    vt[0]  = mk(0,0,0,0,0,0,2'b11,3,3,1, 16'h1111,16'h2222,0,0);
    vt[1]  = mk(0,1,1,5,0,0,2'b00,0,0,0, 16'h1111,16'h2222,0,0);
    vt[2]  = mk(0,1,0,0,0,0,2'b01,5,0,0, 16'hBEEF,16'h2222,0,0);
    vt[3]  = mk(0,1,0,0,0,0,2'b11,5,5,0, 16'h00A5,16'h00A5,0,0);
    vt[4]  = mk(0,0,0,0,0,0,2'b11,5,5,0, 16'h0003,16'h0003,0,0);
    vt[5]  = mk(0,0,0,0,0,0,2'b01,5,0,0, 16'h1111,16'h2222,0,0);
    vt[6]  = mk(0,1,1,2,1,0,2'b00,0,0,0, 16'h1111,16'h2222,0,0);
    vt[7]  = mk(0,1,1,7,0,0,2'b01,2,0,0, 16'hBEEF,16'h2222,0,1);
    vt[8]  = mk(0,1,1,7,0,0,2'b01,2,0,0, 16'h00A5,16'h2222,0,0);
    vt[9]  = mk(0,1,0,0,0,0,2'b11,7,2,0, 16'hBEEF,16'h0003,0,0);
    vt[10] = mk(0,1,1,4,0,1,2'b00,0,0,0, 16'h1111,16'h2222,0,0);
    vt[11] = mk(0,1,1,8,0,1,2'b00,0,0,0, 16'h1111,16'h2222,0,0);
    vt[12] = mk(0,1,1,4,0,0,2'b00,0,0,0, 16'h1111,16'h2222,0,0);
    vt[13] = mk(0,0,0,0,0,0,2'b01,4,0,1, 16'hBEEF,16'h2222,1,0);
    vt[14] = mk(0,1,1,1,1,0,2'b00,0,0,0, 16'h1111,16'h2222,0,0);
    vt[15] = mk(1,1,0,0,0,0,2'b01,1,0,0, 16'hBEEF,16'h2222,0,1);
    vt[16] = mk(1,1,0,0,0,0,2'b01,1,0,0, 16'hBEEF,16'h2222,0,1);
    vt[17] = mk(1,1,0,0,0,0,2'b01,1,0,0, 16'hBEEF,16'h2222,0,1);
    vt[18] = mk(0,1,0,0,0,0,2'b01,1,0,0, 16'hBEEF,16'h2222,0,1);
    vt[19] = mk(0,1,0,0,0,0,2'b01,1,0,0, 16'h00A5,16'h2222,0,0);
    vt[20] = mk(0,1,1,6,1,0,2'b00,0,0,0, 16'h1111,16'h2222,0,0);
    vt[21] = mk(0,1,0,0,0,0,2'b10,6,6,0, 16'h1111,16'hBEEF,0,1);
    vt[22] = mk(0,0,0,0,0,0,2'b10,6,6,0, 16'h1111,16'h00A5,0,0);

    drive_idle();
    n_rst    = 0;
    rf_data  = {16'h2222, 16'h1111};
    stg_data = {16'h0003, 16'h00A5, 16'hBEEF};
    stg_ps   = 3'b010;
    rf_ps    = 0;
`ifdef BYPASS_PERF_EN
    perf_clr = 0;
`endif

    // ---- Reset sequence --------------------------------------------------
    next_cycle();
    rd_use = 2'b11; rd_addr = {4'd3, 4'd3};
    #3;
    chk("rst_op0", 32'(op_data[15:0]), 32'h1111);
    chk("rst_stall", 32'(stall), 32'h0);
    next_cycle();
    n_rst = 1;
    rd_use = 2'b00;
    drive_issue(1, 1, 3, 0, 0); next_cycle();
    drive_issue(1, 1, 3, 0, 0); next_cycle();
    drive_issue(1, 1, 3, 1, 0); next_cycle();
    // Three valid r3 writers in flight, the youngest a load.
    rd_use = 2'b01; rd_addr = {4'd0, 4'd3};
    #2;
    chk("pre_rst_stall", 32'(stall), 32'h1);
    n_rst = 0;   // asynchronous assertion mid-cycle
    #1;
    chk("async_rst_stall", 32'(stall), 32'h0);
    chk("async_rst_op0", 32'(op_data[15:0]), 32'h1111);
    next_cycle();
    #2;
    n_rst = 1;
    drive_idle();
    next_cycle();
    rd_use = 2'b01; rd_addr = {4'd0, 4'd3};
    #3;
    chk("post_rst_op0", 32'(op_data[15:0]), 32'h1111);
    chk("post_rst_stall", 32'(stall), 32'h0);
    next_cycle();

    // ---- Table-driven vectors --------------------------------------------
    for (int i = 0; i < NVEC; i++) begin
      hold = vt[i].hold;
      drive_issue(vt[i].iv, vt[i].iuse, vt[i].iaddr, vt[i].iload, vt[i].iwps);
      rd_use  = vt[i].ruse;
      rd_addr = {vt[i].ra1, vt[i].ra0};
      read_ps = vt[i].rps;
      #3;
      chk($sformatf("vec%0d_op0", i), 32'(op_data[15:0]), 32'(vt[i].e0));
      chk($sformatf("vec%0d_op1", i), 32'(op_data[31:16]), 32'(vt[i].e1));
      chk($sformatf("vec%0d_ps", i), 32'(op_ps), 32'(vt[i].eps));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].est));
      next_cycle();
    end
    drive_idle();

`ifdef BYPASS_PERF_EN
    // ---- Performance counters --------------------------------------------
    perf_clr = 1; next_cycle();
    perf_clr = 0;
    #3;
    chk("perf_clr_stall", perf_stall_cnt, 32'd0);
    chk("perf_clr_fwd", perf_fwd_cnt, 32'd0);
    drive_issue(1, 1, 2, 1, 0); next_cycle();
    drive_issue(1, 0, 0, 0, 0); rd_use = 2'b01; rd_addr = {4'd0, 4'd2};
    next_cycle();
    next_cycle();
    drive_idle();
    #3;
    chk("perf_loaduse_stall", perf_stall_cnt, 32'd1);
    perf_clr = 1; next_cycle();
    perf_clr = 0;
    #3;
    chk("perf_clr2_stall", perf_stall_cnt, 32'd0);
    chk("perf_clr2_fwd", perf_fwd_cnt, 32'd0);
    drive_issue(1, 1, 5, 0, 0); next_cycle();
    rd_use = 2'b11; rd_addr = {4'd5, 4'd5};
    repeat (4) next_cycle();
    drive_idle();
    #3;
    chk("perf_fwd_8", perf_fwd_cnt, 32'd8);
    chk("perf_fwd_nostall", perf_stall_cnt, 32'd0);
    next_cycle();
`endif

    // ---- Randomized run against the reference model ----------------------
    n_rst = 0;
    next_cycle();
    n_rst = 1;
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      hold    = ($urandom_range(3) == 0);
      drive_issue($urandom_range(3) != 0, $urandom_range(1), 4'($urandom_range(3)),
                  $urandom_range(2) == 0, $urandom_range(1));
      rd_use  = 2'($urandom_range(3));
      rd_addr = {4'($urandom_range(3)), 4'($urandom_range(3))};
      read_ps = $urandom_range(1);
      rf_ps   = $urandom_range(1);
      rf_data = {16'($urandom), 16'($urandom)};
      stg_data = {16'($urandom), 16'($urandom), 16'($urandom)};
      stg_ps  = 3'($urandom);
`ifdef BYPASS_PERF_EN
      perf_clr = ($urandom_range(15) == 0);
`endif
      #3;
      model_eval(e0, e1, eps, est, nfwd);
      chk($sformatf("rnd%0d_op0", c), 32'(op_data[15:0]), 32'(e0));
      chk($sformatf("rnd%0d_op1", c), 32'(op_data[31:16]), 32'(e1));
      chk($sformatf("rnd%0d_ps", c), 32'(op_ps), 32'(eps));
      chk($sformatf("rnd%0d_stall", c), 32'(stall), 32'(est));
`ifdef BYPASS_PERF_EN
      chk($sformatf("rnd%0d_pstall", c), perf_stall_cnt, mdl_stall_cnt);
      chk($sformatf("rnd%0d_pfwd", c), perf_fwd_cnt, mdl_fwd_cnt);
      if (perf_clr) begin
        mdl_stall_cnt = '0;
        mdl_fwd_cnt   = '0;
      end else begin
        if (est && !hold) mdl_stall_cnt = mdl_stall_cnt + 1;
        if (issue_valid && !est) mdl_fwd_cnt = mdl_fwd_cnt + 32'(nfwd);
      end
`endif
      model_clock(est);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
